jtkunio_gfx_arb: RTL and testbench

JTKUNIO_GFX_ARB -- requirements
Module: jtkunio_gfx_arb

---
 rtl/jtkunio_gfx_pkg.sv | 13 +
 rtl/jtkunio_gfx_cache.sv | 47 ++++
 rtl/jtkunio_gfx_arb.sv | 132 +++++++++++++
 tb/tb_jtkunio_gfx_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_gfx_pkg.sv
// Shared definitions for the Kunio graphics SDRAM arbiter: FSM encoding and
// the SDRAM word-address width.
package jtkunio_gfx_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jtkunio_gfx_cache.sv
// One-entry read cache for a graphics slot: tag, 32-bit data and valid bit,
// refilled by the arbiter and compared combinationally against the live address.
module jtkunio_gfx_cache #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_tag_i,
  input  logic [31:0]   fill_data_i,
  output logic [31:0]   dout_o,
  output logic          ok_o
);

  logic [AW-1:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (fill_i) begin
      tag_d   = fill_tag_i;
      data_d  = fill_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ok_o   = cs_i & valid_q & (addr_i == tag_q);
  assign dout_o = data_q;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Two-slot SDRAM read arbiter for the char/scroll graphics caches. Slot 0 has
// fixed priority; each fill is a two-beat 16-bit burst assembled into 32 bits.
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter int                  SLOT0_AW     = 14,
  parameter int                  SLOT1_AW     = 17,
  parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [31:0]         slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [31:0]         slot1_dout,
  output logic                slot1_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_dst,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  localparam int LAT_AW = (SLOT0_AW > SLOT1_AW) ? SLOT0_AW : SLOT1_AW;

  arb_state_e          state_q, state_d;
  logic                win_q, win_d;
  logic [LAT_AW-1:0]   lat_q, lat_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic [15:0]         stage_q, stage_d;

  logic                miss0, miss1, fill0, fill1;
  logic [SDRAM_AW-1:0] addr0_x, addr1_x;

  assign miss0   = slot0_cs & ~slot0_ok;
  assign miss1   = slot1_cs & ~slot1_ok;
  // Slot addresses count 32-bit words; SDRAM counts 16-bit words.
  assign addr0_x = SDRAM_AW'({slot0_addr, 1'b0});
  assign addr1_x = SLOT1_OFFSET + SDRAM_AW'({slot1_addr, 1'b0});

  assign fill0 = (state_q == ST_WAIT) & data_rdy & ~win_q;
  assign fill1 = (state_q == ST_WAIT) & data_rdy &  win_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    req_d   = req_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (miss0 | miss1) begin
          win_d   = ~miss0;
          lat_d   = miss0 ? LAT_AW'(slot0_addr) : LAT_AW'(slot1_addr);
          addr_d  = miss0 ? addr0_x : addr1_x;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A coincident data_rdy completes the burst and leaves the low half as staged.
        if (data_rdy) begin
          state_d = ST_IDLE;
        end else if (data_dst) begin
          stage_d = data_read;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      lat_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      stage_q <= stage_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  jtkunio_gfx_cache #(.AW(SLOT0_AW)) u_cache0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_i       (slot0_cs),
    .addr_i     (slot0_addr),
    .fill_i     (fill0),
    .fill_tag_i (lat_q[SLOT0_AW-1:0]),
    .fill_data_i({data_read, stage_q}),
    .dout_o     (slot0_dout),
    .ok_o       (slot0_ok)
  );

  jtkunio_gfx_cache #(.AW(SLOT1_AW)) u_cache1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_i       (slot1_cs),
    .addr_i     (slot1_addr),
    .fill_i     (fill1),
    .fill_tag_i (lat_q[SLOT1_AW-1:0]),
    .fill_data_i({data_read, stage_q}),
    .dout_o     (slot1_dout),
    .ok_o       (slot1_ok)
  );

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Directed bench for jtkunio_gfx_arb with hand-computed SDRAM addresses and
// cache contents; inputs change 1 time unit after the rising edge.
module tb_jtkunio_gfx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slot0_cs;
  logic [13:0] slot0_addr;
  logic [31:0] slot0_dout;
  logic        slot0_ok;
  logic        slot1_cs;
  logic [16:0] slot1_addr;
  logic [31:0] slot1_dout;
  logic        slot1_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtkunio_gfx_arb #(
    .SLOT0_AW    (14),
    .SLOT1_AW    (17),
    .SLOT1_OFFSET(22'h010000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot0_cs   (slot0_cs),
    .slot0_addr (slot0_addr),
    .slot0_dout (slot0_dout),
    .slot0_ok   (slot0_ok),
    .slot1_cs   (slot1_cs),
    .slot1_addr (slot1_addr),
    .slot1_dout (slot1_dout),
    .slot1_ok   (slot1_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_dst   (data_dst),
    .data_rdy   (data_rdy),
    .data_read  (data_read)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input int exp_wait, input logic [21:0] exp_addr);
    int n = 0;
    while (!sdram_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'd0, sdram_req}, 32'd1);
    chk({tag, "_lat"}, n, exp_wait);
    chk({tag, "_addr"}, {10'd0, sdram_addr}, {10'd0, exp_addr});
  endtask

  task automatic do_ack(input string tag, input int delay);
    repeat (delay) step();
    chk({tag, "_req_held"}, {31'd0, sdram_req}, 32'd1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, sdram_req}, 32'd0);
  endtask

  task automatic do_data(input logic [15:0] dst_v, input logic [15:0] rdy_v);
    data_dst  = 1'b1;
    data_read = dst_v;
    step();
    data_dst  = 1'b0;
    data_rdy  = 1'b1;
    data_read = rdy_v;
    step();
    data_rdy  = 1'b0;
    data_read = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    slot0_cs   = 1'b1;
    slot0_addr = 14'h0000;
    slot1_cs   = 1'b0;
    slot1_addr = 17'h00000;
    sdram_ack  = 1'b0;
    data_dst   = 1'b0;
    data_rdy   = 1'b0;
    data_read  = 16'h0000;
    repeat (3) step();

    // Reset state: tag 0 matches addr 0 but the entry is invalid
    chk("rst_req",   {31'd0, sdram_req}, 32'd0);
    chk("rst_addr",  {10'd0, sdram_addr}, 32'd0);
    chk("rst_ok0",   {31'd0, slot0_ok}, 32'd0);
    chk("rst_dout0", slot0_dout, 32'd0);
    chk("rst_dout1", slot1_dout, 32'd0);

    // Slot 0 miss at 0x0123, ack after 2 cycles
    rst_n      = 1'b1;
    slot0_addr = 14'h0123;
    wait_req("t25", 1, 22'h000246);
    do_ack("t25", 2);
    data_dst  = 1'b1;
    data_read = 16'hBEEF;
    step();
    data_dst  = 1'b0;
    chk("t25_ok_before_rdy", {31'd0, slot0_ok}, 32'd0);
    data_rdy  = 1'b1;
    data_read = 16'hDEAD;
    step();
    data_rdy  = 1'b0;
    data_read = 16'h0000;
    chk("t25_ok", {31'd0, slot0_ok}, 32'd1);
    chk("t25_dout", slot0_dout, 32'hDEADBEEF);

    // Handshake strobes outside their states are ignored; a hit never requests
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    data_dst = 1'b1; data_read = 16'h5555; step(); data_dst = 1'b0;
    data_rdy = 1'b1; step(); data_rdy = 1'b0; data_read = 16'h0000;
    step();
    chk("ign_req",  {31'd0, sdram_req}, 32'd0);
    chk("ign_ok",   {31'd0, slot0_ok}, 32'd1);
    chk("ign_dout", slot0_dout, 32'hDEADBEEF);

    // Slot 1 miss at 0x00010 with offset 0x10000
    slot0_cs   = 1'b0;
    slot1_cs   = 1'b1;
    slot1_addr = 17'h00010;
    wait_req("t26", 1, 22'h010020);
    do_ack("t26", 0);
    do_data(16'h5678, 16'h1234);
    chk("t26_ok",   {31'd0, slot1_ok}, 32'd1);
    chk("t26_dout", slot1_dout, 32'h12345678);
    slot1_cs = 1'b0;
    step();
    slot1_cs = 1'b1;
    #1;
    chk("t26_rehit", {31'd0, slot1_ok}, 32'd1);
    repeat (3) step();
    chk("t26_noreq", {31'd0, sdram_req}, 32'd0);

    // Simultaneous misses: slot 0 first, then slot 1
    slot0_cs   = 1'b1;
    slot0_addr = 14'h0200;
    slot1_addr = 17'h00020;
    wait_req("t27a", 1, 22'h000400);
    do_ack("t27a", 1);
    do_data(16'h0A0A, 16'h0B0B);
    chk("t27_ok0",   {31'd0, slot0_ok}, 32'd1);
    chk("t27_dout0", slot0_dout, 32'h0B0B0A0A);
    chk("t27_ok1_pending", {31'd0, slot1_ok}, 32'd0);
    wait_req("t27b", 1, 22'h010040);
    do_ack("t27b", 0);
    chk("t27_ok1_wait", {31'd0, slot1_ok}, 32'd0);
    do_data(16'h0C0C, 16'h0D0D);
    chk("t27_ok1",   {31'd0, slot1_ok}, 32'd1);
    chk("t27_dout1", slot1_dout, 32'h0D0D0C0C);
    slot1_cs = 1'b0;

    // Address changes during WAIT: fill uses the latched address
    slot0_addr = 14'h0001;
    wait_req("t28a", 1, 22'h000002);
    do_ack("t28a", 0);
    slot0_addr = 14'h0002;
    do_data(16'h1111, 16'h2222);
    chk("t28_ok_new", {31'd0, slot0_ok}, 32'd0);
    slot0_addr = 14'h0001;
    #1;
    chk("t28_tag_old", {31'd0, slot0_ok}, 32'd1);
    chk("t28_dout",    slot0_dout, 32'h22221111);
    slot0_addr = 14'h0002;
    wait_req("t28b", 1, 22'h000004);
    do_ack("t28b", 0);
    do_data(16'h3333, 16'h4444);
    chk("t28b_ok",   {31'd0, slot0_ok}, 32'd1);
    chk("t28b_dout", slot0_dout, 32'h44443333);

    // dst and rdy together: low half keeps the previously staged 0x3333
    slot0_addr = 14'h0003;
    wait_req("t30", 1, 22'h000006);
    do_ack("t30", 0);
    data_dst  = 1'b1;
    data_rdy  = 1'b1;
    data_read = 16'h7777;
    step();
    data_dst  = 1'b0;
    data_rdy  = 1'b0;
    data_read = 16'h0000;
    chk("t30_ok",   {31'd0, slot0_ok}, 32'd1);
    chk("t30_dout", slot0_dout, 32'h77773333);
    step();
    chk("t30_noreq", {31'd0, sdram_req}, 32'd0);

    // Reset during WAIT abandons the transaction
    slot0_addr = 14'h0004;
    wait_req("t29", 1, 22'h000008);
    do_ack("t29", 0);
    rst_n = 1'b0;
    #1;
    chk("t29_req",   {31'd0, sdram_req}, 32'd0);
    chk("t29_ok",    {31'd0, slot0_ok}, 32'd0);
    chk("t29_addr",  {10'd0, sdram_addr}, 32'd0);
    chk("t29_dout",  slot0_dout, 32'd0);
    data_rdy  = 1'b1;
    data_read = 16'h9999;
    step();
    data_rdy  = 1'b0;
    slot0_cs  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    data_rdy = 1'b1;
    step();
    data_rdy  = 1'b0;
    data_read = 16'h0000;
    chk("t29_noreq", {31'd0, sdram_req}, 32'd0);
    slot0_cs = 1'b1;
    #1;
    chk("t29_ok_after", {31'd0, slot0_ok}, 32'd0);
    chk("t29_dout_after", slot0_dout, 32'd0);
    wait_req("t29b", 1, 22'h000008);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
